// File: rtl/grid_prune_engine_pkg.sv
// Shared types and width helpers for the grid prune engine and its row pruner.
package grid_prune_engine_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // An 8-neighbour count never exceeds 8, so four bits always hold it.
  localparam int NBR_W = 4;

  function automatic int cnt_width(input int width, input int depth);
    return $clog2(width * depth + 1);
  endfunction

  function automatic int pc_width(input int max_passes);
    return $clog2(max_passes + 1);
  endfunction

  function automatic int ra_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/grid_prune_engine_prune_row.sv
// Combinational pruning of one grid row, given the rows directly above and below it.
module prune_row
  import grid_prune_engine_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int THRESH = 4,
  localparam int RM_W  = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] prev_row,
  input  logic [WIDTH-1:0] cur_row,
  input  logic [WIDTH-1:0] next_row,
  output logic [WIDTH-1:0] new_row,
  output logic [RM_W-1:0]  removed
);

  // Zero padding on both sides so edge columns see empty neighbours.
  logic [WIDTH+1:0] prev_pad;
  logic [WIDTH+1:0] cur_pad;
  logic [WIDTH+1:0] next_pad;

  assign prev_pad = {1'b0, prev_row, 1'b0};
  assign cur_pad  = {1'b0, cur_row, 1'b0};
  assign next_pad = {1'b0, next_row, 1'b0};

  // Count neighbours per column, clear sparse occupied cells and tally the removals.
  always_comb begin
    logic [NBR_W-1:0] nbr;
    nbr     = '0;
    new_row = '0;
    removed = '0;
    for (int j = 0; j < WIDTH; j++) begin
      nbr = NBR_W'(prev_pad[j]) + NBR_W'(prev_pad[j+1]) + NBR_W'(prev_pad[j+2]) +
            NBR_W'(cur_pad[j])  + NBR_W'(cur_pad[j+2])  +
            NBR_W'(next_pad[j]) + NBR_W'(next_pad[j+1]) + NBR_W'(next_pad[j+2]);
      new_row[j] = cur_row[j] && (nbr >= NBR_W'(THRESH));
      removed    = removed + RM_W'(cur_row[j] & ~new_row[j]);
    end
  end

endmodule

// File: rtl/grid_prune_engine.sv
// Iterative occupancy-grid pruner: loads rows, prunes one row per cycle, reports totals.
module grid_prune_engine
  import grid_prune_engine_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int DEPTH       = 16,
  parameter int THRESH      = 4,
  parameter int MAX_PASSES  = 255,
  localparam int CNT_W      = cnt_width(WIDTH, DEPTH),
  localparam int PC_W       = pc_width(MAX_PASSES),
  localparam int RA_W       = ra_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_row,
  input  logic             start,
  input  logic             mode,
  input  logic             clear,
  output logic             busy,
  output logic             done,
  output logic             converged,
  output logic             limited,
  output logic [CNT_W-1:0] total_count,
  output logic [CNT_W-1:0] first_pass_count,
  output logic [PC_W-1:0]  pass_count,
  input  logic [RA_W-1:0]  rd_addr,
  output logic [WIDTH-1:0] rd_row
);

  localparam int PTR_W = $clog2(DEPTH + 1);
  localparam int RM_W  = $clog2(WIDTH + 1);
  localparam logic [PTR_W-1:0] PTR_FULL   = PTR_W'(DEPTH);
  localparam logic [RA_W-1:0]  LAST_ROW   = RA_W'(DEPTH - 1);
  localparam logic [RA_W:0]    DEPTH_EXT  = (RA_W + 1)'(DEPTH);
  localparam logic [PC_W-1:0]  PASS_LIMIT = PC_W'(MAX_PASSES);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] grid_q [DEPTH];
  logic [WIDTH-1:0] grid_d [DEPTH];
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [RA_W-1:0]  row_q, row_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic             mode_q, mode_d;
  logic [CNT_W-1:0] pass_rm_q, pass_rm_d;
  logic [CNT_W-1:0] total_q, total_d;
  logic [CNT_W-1:0] first_q, first_d;
  logic [PC_W-1:0]  pass_cnt_q, pass_cnt_d;
  logic             converged_q, converged_d;
  logic             limited_q, limited_d;

  logic [WIDTH-1:0] cur_row;
  logic [WIDTH-1:0] next_row;
  logic [WIDTH-1:0] new_row;
  logic [RM_W-1:0]  row_removed;
  logic [CNT_W-1:0] pass_removed;
  logic [PC_W-1:0]  pass_cnt_inc;

  // Row r is overwritten only after r+1 has been read, so cur/next are still pre-pass values;
  // prev_q keeps the pre-pass copy of row r-1.
  assign cur_row      = grid_q[row_q];
  assign next_row     = (row_q == LAST_ROW) ? '0 : grid_q[row_q + 1'b1];
  assign pass_removed = pass_rm_q + CNT_W'(row_removed);
  assign pass_cnt_inc = pass_cnt_q + 1'b1;

  prune_row #(
    .WIDTH  (WIDTH),
    .THRESH (THRESH)
  ) u_prune_row (
    .prev_row (prev_q),
    .cur_row  (cur_row),
    .next_row (next_row),
    .new_row  (new_row),
    .removed  (row_removed)
  );

  assign load_ready       = (state_q == IDLE) && (ptr_q < PTR_FULL);
  assign busy             = (state_q == RUN);
  assign done             = (state_q == DONE);
  assign converged        = converged_q;
  assign limited          = limited_q;
  assign total_count      = total_q;
  assign first_pass_count = first_q;
  assign pass_count       = pass_cnt_q;
  assign rd_row           = ({1'b0, rd_addr} < DEPTH_EXT) ? grid_q[rd_addr] : '0;

  // Next-state logic for the load / run / done sequencer and its counters.
  always_comb begin
    state_d     = state_q;
    grid_d      = grid_q;
    ptr_d       = ptr_q;
    row_d       = row_q;
    prev_d      = prev_q;
    mode_d      = mode_q;
    pass_rm_d   = pass_rm_q;
    total_d     = total_q;
    first_d     = first_q;
    pass_cnt_d  = pass_cnt_q;
    converged_d = converged_q;
    limited_d   = limited_q;

    case (state_q)
      IDLE: begin
        if (load_valid && load_ready) begin
          grid_d[ptr_q[RA_W-1:0]] = load_row;
          ptr_d                   = ptr_q + 1'b1;
        end
        if (start && (ptr_q == PTR_FULL)) begin
          state_d     = RUN;
          mode_d      = mode;
          row_d       = '0;
          prev_d      = '0;
          pass_rm_d   = '0;
          total_d     = '0;
          first_d     = '0;
          pass_cnt_d  = '0;
          converged_d = 1'b0;
          limited_d   = 1'b0;
        end
      end

      RUN: begin
        grid_d[row_q] = new_row;
        prev_d        = cur_row;
        if (row_q == LAST_ROW) begin
          pass_cnt_d = pass_cnt_inc;
          total_d    = total_q + pass_removed;
          if (pass_cnt_q == '0) begin
            first_d = pass_removed;
          end
          row_d     = '0;
          prev_d    = '0;
          pass_rm_d = '0;
          if (pass_removed == '0) begin
            converged_d = 1'b1;
            state_d     = DONE;
          end else if (!mode_q) begin
            state_d = DONE;
          end else if (pass_cnt_inc == PASS_LIMIT) begin
            limited_d = 1'b1;
            state_d   = DONE;
          end
        end else begin
          row_d     = row_q + 1'b1;
          pass_rm_d = pass_removed;
        end
      end

      DONE: begin
        if (clear) begin
          state_d     = IDLE;
          ptr_d       = '0;
          total_d     = '0;
          first_d     = '0;
          pass_cnt_d  = '0;
          converged_d = 1'b0;
          limited_d   = 1'b0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, grid and counter registers; reset empties the grid and abandons any run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      for (int i = 0; i < DEPTH; i++) begin
        grid_q[i] <= '0;
      end
      ptr_q       <= '0;
      row_q       <= '0;
      prev_q      <= '0;
      mode_q      <= 1'b0;
      pass_rm_q   <= '0;
      total_q     <= '0;
      first_q     <= '0;
      pass_cnt_q  <= '0;
      converged_q <= 1'b0;
      limited_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      grid_q      <= grid_d;
      ptr_q       <= ptr_d;
      row_q       <= row_d;
      prev_q      <= prev_d;
      mode_q      <= mode_d;
      pass_rm_q   <= pass_rm_d;
      total_q     <= total_d;
      first_q     <= first_d;
      pass_cnt_q  <= pass_cnt_d;
      converged_q <= converged_d;
      limited_q   <= limited_d;
    end
  end

endmodule

// File: tb/tb_grid_prune_engine.sv
// Directed testbench for grid_prune_engine: a 10x10 instance and a 4x4 instance with a two-pass limit.
module tb_grid_prune_engine;

   logic        clock;
   logic        reset;
   logic        sel;
   logic        loadValid;
   logic [9:0]  loadRow;
   logic        start;
   logic        mode;
   logic        clear;
   logic [3:0]  rdAddr;

   logic        loadReadyA, busyA, doneA, convergedA, limitedA;
   logic [6:0]  totalA, firstA;
   logic [7:0]  passA;
   logic [9:0]  rdRowA;

   logic        loadReadyB, busyB, doneB, convergedB, limitedB;
   logic [4:0]  totalB, firstB;
   logic [1:0]  passB;
   logic [3:0]  rdRowB;

   logic        loadReadyObs, busyObs, doneObs, convObs, limObs;
   logic [31:0] totalObs, firstObs, passObs, rdRowObs;

   int          assertCount;
   int          failCount;
   int          cycles;
   string       gridRows [10];

   // Main instance: the 10x10 grid used for most scenarios
   grid_prune_engine #(
      .WIDTH(10), .DEPTH(10), .THRESH(4), .MAX_PASSES(255)
   ) dutA (
      .clk(clock), .rst(reset),
      .load_valid(loadValid & ~sel), .load_ready(loadReadyA), .load_row(loadRow),
      .start(start & ~sel), .mode(mode), .clear(clear & ~sel),
      .busy(busyA), .done(doneA), .converged(convergedA), .limited(limitedA),
      .total_count(totalA), .first_pass_count(firstA), .pass_count(passA),
      .rd_addr(rdAddr), .rd_row(rdRowA)
   );

   // Small instance with a two-pass cap, for the limit, partial-load and mid-run reset scenarios
   grid_prune_engine #(
      .WIDTH(4), .DEPTH(4), .THRESH(4), .MAX_PASSES(2)
   ) dutB (
      .clk(clock), .rst(reset),
      .load_valid(loadValid & sel), .load_ready(loadReadyB), .load_row(loadRow[3:0]),
      .start(start & sel), .mode(mode), .clear(clear & sel),
      .busy(busyB), .done(doneB), .converged(convergedB), .limited(limitedB),
      .total_count(totalB), .first_pass_count(firstB), .pass_count(passB),
      .rd_addr(rdAddr[1:0]), .rd_row(rdRowB)
   );

   // Route whichever instance is selected onto one set of observation signals
   assign loadReadyObs = sel ? loadReadyB : loadReadyA;
   assign busyObs      = sel ? busyB : busyA;
   assign doneObs      = sel ? doneB : doneA;
   assign convObs      = sel ? convergedB : convergedA;
   assign limObs       = sel ? limitedB : limitedA;
   assign totalObs     = sel ? 32'(totalB) : 32'(totalA);
   assign firstObs     = sel ? 32'(firstB) : 32'(firstA);
   assign passObs      = sel ? 32'(passB) : 32'(passA);
   assign rdRowObs     = sel ? 32'(rdRowB) : 32'(rdRowA);

   // Free-running clock, 10 time units per period
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Advance one clock and settle just past the rising edge
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Single comparison point: counts every check and reports any disagreement
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: observed %0d (0x%0h), expected %0d (0x%0h)", tag, observed, observed, expected, expected);
      end
   endtask

   // Turn a picture row ('@' = roll) into a row word, character j becoming bit j
   function automatic logic [9:0] strToRow(input string s);
      logic [9:0] r;
      r = '0;
      for (int j = 0; j < s.len() && j < 10; j++) begin
         if (s[j] == "@") r[j] = 1'b1;
      end
      return r;
   endfunction

   // Push rows first..first+count-1 of gridRows through the load port, one per cycle
   task automatic loadGrid(input int first, input int count);
      for (int r = first; r < first + count; r++) begin
         loadRow   = strToRow(gridRows[r]);
         loadValid = 1'b1;
         tick();
      end
      loadValid = 1'b0;
      loadRow   = '0;
   endtask

   // Pulse start, then flip mode to show it is only sampled at start; count cycles until done
   task automatic applyStimulus(input logic runMode, output int elapsed);
      start = 1'b1;
      mode  = runMode;
      tick();
      start   = 1'b0;
      mode    = ~runMode;
      elapsed = 1;
      while (!doneObs && elapsed < 2000) begin
         tick();
         elapsed++;
      end
      checkOutput("doneReached", 32'(doneObs), 32'd1);
   endtask

   // One-cycle clear pulse
   task automatic clearRun();
      clear = 1'b1;
      tick();
      clear = 1'b0;
   endtask

   // Read back one row combinationally and compare it
   task automatic checkRow(input string tag, input int addr, input logic [31:0] expected);
      rdAddr = 4'(addr);
      #1;
      checkOutput(tag, rdRowObs, expected);
   endtask

   // Compare the end-of-run result bundle in one go
   task automatic checkResults(input string tag, input int expCycles, input int expFirst, input int expTotal,
                               input int expPass, input logic expConv, input logic expLim);
      checkOutput({tag, ".cycles"}, 32'(cycles), 32'(expCycles));
      checkOutput({tag, ".first"}, firstObs, 32'(expFirst));
      checkOutput({tag, ".total"}, totalObs, 32'(expTotal));
      checkOutput({tag, ".passes"}, passObs, 32'(expPass));
      checkOutput({tag, ".converged"}, 32'(convObs), 32'(expConv));
      checkOutput({tag, ".limited"}, 32'(limObs), 32'(expLim));
      checkOutput({tag, ".busy"}, 32'(busyObs), 32'd0);
   endtask

   // Directed scenario sequence with hand-computed expectations
   initial begin
      assertCount = 0;
      failCount   = 0;
      reset = 1'b1; sel = 1'b0; loadValid = 1'b0; loadRow = '0;
      start = 1'b0; mode = 1'b0; clear = 1'b0; rdAddr = '0;
      repeat (2) tick();
      reset = 1'b0;
      tick();

      // Reset state of the 10x10 instance
      checkOutput("rst.loadReady", 32'(loadReadyObs), 32'd1);
      checkOutput("rst.busy", 32'(busyObs), 32'd0);
      checkOutput("rst.done", 32'(doneObs), 32'd0);
      checkOutput("rst.total", totalObs, 32'd0);
      checkOutput("rst.passes", passObs, 32'd0);
      checkRow("rst.row0", 0, 32'd0);

      // Puzzle example: passes remove 13,12,7,5,2,1,1,1,1,0 -> 43 total over 10 passes
      gridRows = '{"..@@.@@@@.", "@@@.@.@.@@", "@@@@@.@.@@", "@.@@@@..@.", "@@.@@@@.@@",
                   ".@@@@@@@.@", ".@.@.@.@@@", "@.@@@.@@@@", ".@@@@@@@@.", "@.@.@@@.@."};
      loadGrid(0, 10);
      checkOutput("puzzle.loadFull", 32'(loadReadyObs), 32'd0);
      applyStimulus(1'b1, cycles);
      checkResults("puzzle", 101, 13, 43, 10, 1'b1, 1'b0);

      // start is ignored while results are held
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      checkOutput("doneStart.done", 32'(doneObs), 32'd1);
      checkOutput("doneStart.total", totalObs, 32'd43);

      // clear returns to IDLE with zeroed results and an empty load pointer
      clearRun();
      checkOutput("clear.done", 32'(doneObs), 32'd0);
      checkOutput("clear.total", totalObs, 32'd0);
      checkOutput("clear.passes", passObs, 32'd0);
      checkOutput("clear.loadReady", 32'(loadReadyObs), 32'd1);

      // Full 4x4 block in the corner, single pass: only the four corners (3 neighbours) go
      gridRows = '{"@@@@......", "@@@@......", "@@@@......", "@@@@......", "..........",
                   "..........", "..........", "..........", "..........", ".........."};
      loadGrid(0, 10);
      applyStimulus(1'b0, cycles);
      checkResults("block1", 11, 4, 4, 1, 1'b0, 1'b0);
      checkRow("block1.row0", 0, 32'h006);
      checkRow("block1.row1", 1, 32'h00F);
      checkRow("block1.row3", 3, 32'h006);
      clearRun();

      // Same block to fixpoint: after the corners go every remaining cell keeps >= 4 neighbours
      loadGrid(0, 10);
      applyStimulus(1'b1, cycles);
      checkResults("block2", 21, 4, 4, 2, 1'b1, 1'b0);
      checkRow("block2.row2", 2, 32'h00F);
      checkRow("block2.row3", 3, 32'h006);
      clearRun();

      // Staircase shape erodes 4, 3, 2, 0 and empties completely
      gridRows = '{"@@@@......", "@@@@......", "@.........", "..........", "..........",
                   "..........", "..........", "..........", "..........", ".........."};
      loadGrid(0, 10);
      applyStimulus(1'b1, cycles);
      checkResults("stair", 41, 4, 9, 4, 1'b1, 1'b0);
      checkRow("stair.row0", 0, 32'd0);
      checkRow("stair.row1", 1, 32'd0);
      clearRun();

      // Empty grid converges on the very first pass
      for (int r = 0; r < 10; r++) gridRows[r] = "..........";
      loadGrid(0, 10);
      applyStimulus(1'b1, cycles);
      checkResults("empty", 11, 0, 0, 1, 1'b1, 1'b0);

      // Switch to the 4x4 instance: start with only three rows loaded must be ignored
      sel = 1'b1;
      #1;
      gridRows = '{"@@@@", "@@@@", "@...", "....", "", "", "", "", "", ""};
      loadGrid(0, 3);
      start = 1'b1; mode = 1'b1;
      tick();
      start = 1'b0;
      tick();
      checkOutput("partial.busy", 32'(busyObs), 32'd0);
      checkOutput("partial.loadReady", 32'(loadReadyObs), 32'd1);

      // Fourth row completes the grid; a fifth row offered afterwards is refused
      loadGrid(3, 1);
      checkOutput("full4.loadReady", 32'(loadReadyObs), 32'd0);
      loadRow = 10'h00F; loadValid = 1'b1;
      tick();
      loadValid = 1'b0; loadRow = '0;

      // Staircase on the capped instance: 4 then 3 removed, stops at the two-pass limit
      applyStimulus(1'b1, cycles);
      checkResults("limit", 9, 4, 7, 2, 1'b0, 1'b1);
      checkRow("limit.row0", 0, 32'h2);
      checkRow("limit.row1", 1, 32'h2);
      checkRow("limit.row3", 3, 32'h0);

      // Reset in the middle of pass 2 discards everything
      clearRun();
      loadGrid(0, 4);
      start = 1'b1; mode = 1'b1;
      tick();
      start = 1'b0;
      repeat (6) tick();
      checkOutput("midRun.busy", 32'(busyObs), 32'd1);
      checkOutput("midRun.passes", passObs, 32'd1);
      checkOutput("midRun.first", firstObs, 32'd4);
      reset = 1'b1;
      #1;
      checkOutput("abort.busy", 32'(busyObs), 32'd0);
      checkOutput("abort.done", 32'(doneObs), 32'd0);
      checkOutput("abort.total", totalObs, 32'd0);
      checkOutput("abort.first", firstObs, 32'd0);
      checkOutput("abort.passes", passObs, 32'd0);
      checkOutput("abort.loadReady", 32'(loadReadyObs), 32'd1);
      checkRow("abort.row0", 0, 32'd0);
      checkRow("abort.row1", 1, 32'd0);
      tick();
      reset = 1'b0;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
